rr_bus_arbiter_16: RTL

- Round-robin arbiter and sequencer for the 16-input, 32-bit shared-bus word mux.
- Takes 16 requesters, grants one at a time, and drives the mux's 4-bit select.
- Qualifies the muxed word toward a single sink with a valid/ready handshake.
- Enforces a per-grant burst limit so no requester starves the others.

---
 rtl/rr_bus_arbiter_16.sv | 112 +++++++++++
 1 files changed

// File: rtl/rr_bus_arbiter_16.sv
// Round-robin arbiter/sequencer for the 16-input shared-bus word mux.
// Grants one requester at a time, drives the mux select and enforces a per-grant burst cap.
module rr_bus_arbiter_16 #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] req,
    input  logic [15:0] last,
    input  logic        out_ready,
    output logic [3:0]  select,
    output logic [15:0] grant,
    output logic        out_valid,
    output logic        busy
);

    localparam int unsigned BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_FINAL = BW'(MAX_BURST - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state, state_n;
    logic [3:0]    ptr, ptr_n;
    logic [3:0]    select_n;
    logic [15:0]   grant_n;
    logic [BW-1:0] beat_cnt, beat_cnt_n;

    logic          beat;
    logic          release_now;
    logic [3:0]    arb_base;
    logic [3:0]    arb_idx;

    // First set bit of v, scanning upward from p and wrapping 15 -> 0.
    function automatic logic [3:0] pick(input logic [15:0] v, input logic [3:0] p);
        logic [3:0] idx;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = p + 4'(i);
            if (!found && v[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    assign busy      = (state == GRANT);
    assign out_valid = busy & req[select];
    assign beat      = out_valid & out_ready;

    // A withdrawn request releases without a beat; otherwise release on end-of-packet or burst cap.
    assign release_now = busy & (~req[select] | (beat & (last[select] | (beat_cnt == BURST_FINAL))));

    // On release the current grantee drops to lowest priority, so the scan starts just past it.
    assign arb_base = (state == IDLE) ? ptr : (select + 4'd1);
    assign arb_idx  = pick(req, arb_base);

    always_comb begin
        state_n    = state;
        ptr_n      = ptr;
        select_n   = select;
        grant_n    = grant;
        beat_cnt_n = beat_cnt;
        case (state)
            IDLE: begin
                if (|req) begin
                    select_n   = arb_idx;
                    grant_n    = 16'h1 << arb_idx;
                    beat_cnt_n = '0;
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_n = select + 4'd1;
                    if (|req) begin
                        select_n   = arb_idx;
                        grant_n    = 16'h1 << arb_idx;
                        beat_cnt_n = '0;
                    end else begin
                        grant_n = '0;
                        state_n = IDLE;
                    end
                end else if (beat) begin
                    beat_cnt_n = beat_cnt + BW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            select   <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            select   <= select_n;
            grant    <= grant_n;
            beat_cnt <= beat_cnt_n;
        end
    end

endmodule
